core_imem_rsp: RTL and testbench

- Instruction-memory responder on the far end of the IFU fetch bus: accepts every `bus_req_valid`/`bus_req_addr` beat from the IFU and returns `bus_rsp_valid`/`bus_rsp_data` after a fixed, parameterised latency.
- Holds the program in an internal word array, loaded through a side programming port, so fetch timing can be swept by parameter alone.
- Sits between `core_ifu_top` and the bench/SoC top; the fetch bus has no ready, so this block never back-pressures.

---
 rtl/core_bus_pkg.sv | 17 +
 rtl/core_imem_ram.sv | 25 ++
 rtl/core_imem_rsp.sv | 131 +++++++++++++
 tb/tb_core_imem_rsp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Types and constants shared by the fetch-bus and data-bus memory responders.
package core_bus_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } bus_req_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } bus_rsp_t;

endpackage

// File: rtl/core_imem_ram.sv
// Single-read/single-write synchronous word RAM, read-before-write on a shared address.
module core_imem_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem_reg [0:(1<<AW)-1];
  logic [31:0] rd_data_reg;

  // Read port holds its last word while rd_en is low.
  always_ff @(posedge clk) begin
    if (we) mem_reg[wr_addr] <= wr_data;
    if (rd_en) rd_data_reg <= mem_reg[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/core_imem_rsp.sv
// Instruction-memory responder: fixed-latency, never back-pressuring fetch server
// with a side programming port into the program array.
module core_imem_rsp
  import core_bus_pkg::*;
#(
  parameter int          AW       = 10,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = RV_NOP
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bus_req_valid,
  input  logic [31:0]   bus_req_addr,
  output logic          bus_rsp_valid,
  output logic [31:0]   bus_rsp_data,
  output logic          bus_rsp_err,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_wdata,
  output logic          err_sticky,
  output logic [31:0]   rsp_count
);

  bus_req_t      req;
  logic          req_err;
  logic [AW-1:0] req_idx;

  assign req     = '{valid: bus_req_valid, addr: bus_req_addr};
  assign req_err = (req.addr[1:0] != 2'b00) || (req.addr[31:AW+2] != '0);
  assign req_idx = req.addr[AW+1:2];

  // Final-stage view of the request; the output register adds the last cycle.
  logic          fin_valid;
  logic          fin_err;
  logic [AW-1:0] fin_idx;

  generate
    if (LATENCY <= 1) begin : g_direct
      assign fin_valid = req.valid;
      assign fin_err   = req_err;
      assign fin_idx   = req_idx;
    end else begin : g_pipe
      localparam int DEPTH = LATENCY - 1;
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic          valid_reg;
        logic          err_reg;
        logic [AW-1:0] idx_reg;
        logic          valid_in;
        logic          err_in;
        logic [AW-1:0] idx_in;

        if (gi == 0) begin : g_head
          assign valid_in = req.valid;
          assign err_in   = req_err;
          assign idx_in   = req_idx;
        end else begin : g_link
          assign valid_in = g_stage[gi-1].valid_reg;
          assign err_in   = g_stage[gi-1].err_reg;
          assign idx_in   = g_stage[gi-1].idx_reg;
        end

        always_ff @(posedge clk) begin
          if (rst) valid_reg <= 1'b0;
          else     valid_reg <= valid_in;
          err_reg <= err_in;
          idx_reg <= idx_in;
        end
      end
      assign fin_valid = g_stage[DEPTH-1].valid_reg;
      assign fin_err   = g_stage[DEPTH-1].err_reg;
      assign fin_idx   = g_stage[DEPTH-1].idx_reg;
    end
  endgenerate

  logic        ram_rd_en;
  logic [31:0] ram_rd_data;

  // Faulting fetches skip the array so its output keeps the last good word.
  assign ram_rd_en = fin_valid && !fin_err && !rst;

  core_imem_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_addr (fin_idx),
    .rd_data (ram_rd_data),
    .we      (prog_we),
    .wr_addr (prog_addr),
    .wr_data (prog_wdata)
  );

  logic        rsp_valid_reg;
  logic        rsp_err_reg;
  logic        rsp_seen_reg;
  logic        err_sticky_reg;
  logic [31:0] rsp_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_reg  <= 1'b0;
      rsp_err_reg    <= 1'b0;
      rsp_seen_reg   <= 1'b0;
      err_sticky_reg <= 1'b0;
      rsp_count_reg  <= '0;
    end else begin
      rsp_valid_reg <= fin_valid;
      rsp_count_reg <= rsp_count_reg + {31'b0, fin_valid};
      if (fin_valid) begin
        rsp_err_reg  <= fin_err;
        rsp_seen_reg <= 1'b1;
        if (fin_err) err_sticky_reg <= 1'b1;
      end
    end
  end

  // rsp_seen_reg forces zero data after reset, since the RAM read register is not reset.
  bus_rsp_t rsp;

  always_comb begin
    rsp       = '0;
    rsp.valid = rsp_valid_reg;
    rsp.err   = rsp_err_reg;
    if (rsp_seen_reg) rsp.data = rsp_err_reg ? NOP_WORD : ram_rd_data;
  end

  assign bus_rsp_valid = rsp.valid;
  assign bus_rsp_err   = rsp.err;
  assign bus_rsp_data  = rsp.data;
  assign err_sticky    = err_sticky_reg;
  assign rsp_count     = rsp_count_reg;

endmodule

// File: tb/tb_core_imem_rsp.sv
// Directed bench for core_imem_rsp: three instances at LATENCY 1, 3 and 4 share stimulus.
module tb_core_imem_rsp;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req_valid = 1'b0;
  logic [31:0] bus_req_addr = '0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_wdata = '0;

  logic        v1, e1, s1, v3, e3, s3, v4, e4, s4;
  logic [31:0] d1, c1, d3, c3, d4, c4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_imem_rsp #(.AW(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(v1), .bus_rsp_data(d1), .bus_rsp_err(e1),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .err_sticky(s1), .rsp_count(c1));

  core_imem_rsp #(.AW(10), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(v3), .bus_rsp_data(d3), .bus_rsp_err(e3),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .err_sticky(s3), .rsp_count(c3));

  core_imem_rsp #(.AW(10), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .bus_req_valid(bus_req_valid), .bus_req_addr(bus_req_addr),
    .bus_rsp_valid(v4), .bus_rsp_data(d4), .bus_rsp_err(e4),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .err_sticky(s4), .rsp_count(c4));

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_req_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic prog_word(input logic [9:0] a, input logic [31:0] w);
    prog_we = 1'b1;
    prog_addr = a;
    prog_wdata = w;
    step();
    prog_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h0;
    step();
    step();
    rst = 1'b0;
    bus_req_valid = 1'b0;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", v1); end
    checks++; if (d1 !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", d1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", e1); end
    checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", s1); end
    checks++; if (c1 !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", c1); end
    checks++; if (c4 !== 32'h0) begin errors++; $display("FAIL reset_count4 got %0d exp 0", c4); end
    for (int w = 0; w < 4; w++) prog_word(w[9:0], 32'hA0 + w);
    $display("reset: outputs cleared, words 0..3 programmed");
  endtask

  task automatic test_latency();
    do_reset();
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h0;
    step();
    bus_req_valid = 1'b0;
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL lat1_valid got %b exp 1", v1); end
    checks++; if (d1 !== 32'hA0) begin errors++; $display("FAIL lat1_data got %h exp a0", d1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL lat1_err got %b exp 0", e1); end
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL lat3_early1 got %b exp 0", v3); end
    step();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL lat1_single got %b exp 0", v1); end
    checks++; if (d1 !== 32'hA0) begin errors++; $display("FAIL lat1_hold got %h exp a0", d1); end
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL lat3_early2 got %b exp 0", v3); end
    step();
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL lat3_valid got %b exp 1", v3); end
    checks++; if (d3 !== 32'hA0) begin errors++; $display("FAIL lat3_data got %h exp a0", d3); end
    step();
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL lat3_single got %b exp 0", v3); end
    $display("latency: fetch 0x0 -> a0 at +1 (L1) and +3 (L3)");
  endtask

  task automatic test_streaming();
    logic exp_v;
    logic [31:0] exp_d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus_req_valid = (i < 4);
      bus_req_addr = 32'(4 * i);
      step();
      exp_v = (i >= 2 && i <= 5);
      exp_d = 32'hA0 + 32'(i - 2);
      checks++; if (v3 !== exp_v) begin errors++; $display("FAIL stream_valid[%0d] got %b exp %b", i, v3, exp_v); end
      if (exp_v) begin
        checks++; if (d3 !== exp_d) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, d3, exp_d); end
        checks++; if (e3 !== 1'b0) begin errors++; $display("FAIL stream_err[%0d] got %b exp 0", i, e3); end
      end
    end
    checks++; if (c3 !== 32'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", c3); end
    checks++; if (s3 !== 1'b0) begin errors++; $display("FAIL stream_sticky got %b exp 0", s3); end
    $display("streaming: 4 back-to-back fetches at L3, count %0d", c3);
  endtask

  task automatic test_bubbles();
    logic [7:0] req_v;
    logic [7:0] rsp_v;
    logic [31:0] req_a [8];
    logic [31:0] rsp_d [8];
    req_v = 8'b0000_1101;            // bit i = request in cycle i: 0x0, idle, 0x4, 0x8
    rsp_v = 8'b0011_0100;            // same pattern shifted by two sample points
    req_a = '{32'h0, 32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
    rsp_d = '{32'h0, 32'h0, 32'hA0, 32'h0, 32'hA1, 32'hA2, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus_req_valid = req_v[i];
      bus_req_addr = req_a[i];
      step();
      checks++; if (v3 !== rsp_v[i]) begin errors++; $display("FAIL bubble_valid[%0d] got %b exp %b", i, v3, rsp_v[i]); end
      if (rsp_v[i]) begin
        checks++; if (d3 !== rsp_d[i]) begin errors++; $display("FAIL bubble_data[%0d] got %h exp %h", i, d3, rsp_d[i]); end
      end
    end
    checks++; if (c3 !== 32'd3) begin errors++; $display("FAIL bubble_count got %0d exp 3", c3); end
    $display("bubbles: pattern 1,0,1,1 at L3, count %0d", c3);
  endtask

  task automatic test_faults();
    do_reset();
    checks++; if (s1 !== 1'b0) begin errors++; $display("FAIL fault_sticky_pre got %b exp 0", s1); end
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h2;
    step();
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL fault_mis_valid got %b exp 1", v1); end
    checks++; if (d1 !== NOP) begin errors++; $display("FAIL fault_mis_data got %h exp %h", d1, NOP); end
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL fault_mis_err got %b exp 1", e1); end
    checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL fault_mis_sticky got %b exp 1", s1); end
    bus_req_addr = 32'h0000_1000;
    step();
    checks++; if (d1 !== NOP) begin errors++; $display("FAIL fault_range_data got %h exp %h", d1, NOP); end
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL fault_range_err got %b exp 1", e1); end
    bus_req_addr = 32'h8;
    step();
    checks++; if (d1 !== 32'hA2) begin errors++; $display("FAIL fault_good_data got %h exp a2", d1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL fault_good_err got %b exp 0", e1); end
    checks++; if (s1 !== 1'b1) begin errors++; $display("FAIL fault_good_sticky got %b exp 1", s1); end
    bus_req_addr = 32'h8000_0004;
    step();
    bus_req_valid = 1'b0;
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL fault_top_err got %b exp 1", e1); end
    step();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL fault_idle_valid got %b exp 0", v1); end
    checks++; if (e1 !== 1'b1) begin errors++; $display("FAIL fault_idle_err_hold got %b exp 1", e1); end
    checks++; if (d1 !== NOP) begin errors++; $display("FAIL fault_idle_data_hold got %h exp %h", d1, NOP); end
    checks++; if (c1 !== 32'd4) begin errors++; $display("FAIL fault_count got %0d exp 4", c1); end
    $display("faults: misaligned/out-of-range return NOP with err, sticky holds");
  endtask

  task automatic test_collision();
    prog_we = 1'b1;
    prog_addr = 10'd1;
    prog_wdata = 32'hDEAD_BEEF;
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h4;
    step();
    prog_we = 1'b0;
    checks++; if (d1 !== 32'hA1) begin errors++; $display("FAIL coll_old got %h exp a1", d1); end
    step();
    bus_req_valid = 1'b0;
    checks++; if (d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_new got %h exp deadbeef", d1); end
    step();
    prog_word(10'd1, 32'hA1);
    $display("collision: same-edge write/read returns old word, next read new word");
  endtask

  task automatic test_midflight_reset();
    do_reset();
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h4;
    step();
    bus_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (d4 !== 32'hA1) begin errors++; $display("FAIL mid_pre_data got %h exp a1", d4); end
    checks++; if (c4 !== 32'd1) begin errors++; $display("FAIL mid_pre_count got %0d exp 1", c4); end
    for (int i = 0; i < 3; i++) begin
      bus_req_valid = 1'b1;
      bus_req_addr = 32'(4 * i);
      step();
    end
    rst = 1'b1;
    bus_req_addr = 32'hC;
    step();
    rst = 1'b0;
    bus_req_valid = 1'b0;
    checks++; if (d4 !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", d4); end
    checks++; if (e4 !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b exp 0", e4); end
    checks++; if (s4 !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got %b exp 0", s4); end
    checks++; if (c4 !== 32'h0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", c4); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d] got %b exp 0", i, v4); end
      step();
    end
    checks++; if (c4 !== 32'h0) begin errors++; $display("FAIL mid_post_count got %0d exp 0", c4); end
    bus_req_valid = 1'b1;
    bus_req_addr = 32'h0;
    step();
    bus_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (v4 !== 1'b0) begin errors++; $display("FAIL mid_refetch_early[%0d] got %b exp 0", i, v4); end
      step();
    end
    checks++; if (v4 !== 1'b1) begin errors++; $display("FAIL mid_refetch_valid got %b exp 1", v4); end
    checks++; if (d4 !== 32'hA0) begin errors++; $display("FAIL mid_refetch_data got %h exp a0", d4); end
    $display("midflight reset: in-flight beats dropped, memory kept, count %0d", c4);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_streaming();
    test_bubbles();
    test_faults();
    test_collision();
    test_midflight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
